mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory between two requesters: port 0 is the CPU fetch/execute path and port 1 is the debug/program-loader port.
- Each accepted request is one read or write transfer, sequenced by a 4-state FSM that drives the memory strobes.
- Round-robin arbitration between the two ports.
- Sits between the CPU controller/datapath and the memory model. The memory has a registered read with 1-cycle latency.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory bus around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters' and memory model's view.
interface mem_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, busy,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, busy,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port program/data memory, one transfer per GRANT/ACCESS/RESP pass.
// Define MEM_ARB_FIXED_PRIO_EN to give port 1 (loader) fixed priority instead of round-robin.
module mem_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

    state_t        state;
    logic          owner;
    logic          we_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic [DW-1:0] rdata_q;
    logic          gnt0_q, gnt1_q, done0_q, done1_q;
    logic          mem_rd_q, mem_wr_q, busy_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic          last_owner;
`endif

    logic any_req;
    logic winner;

    always_comb begin
        any_req = bus.req0 | bus.req1;
        winner  = bus.req1;
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            winner = 1'b1;
`else
            winner = ~last_owner;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            we_l        <= 1'b0;
            addr_l      <= '0;
            wdata_l     <= '0;
            rdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_owner  <= 1'b1;
`endif
        end else begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    // Read data is only live on mem_rdata during RESP; capture it on the way out.
                    if (state == RESP && !we_l) rdata_q <= bus.mem_rdata;
                    if (any_req) begin
                        state   <= GRANT;
                        busy_q  <= 1'b1;
                        owner   <= winner;
                        we_l    <= winner ? bus.we1 : bus.we0;
                        addr_l  <= winner ? bus.addr1 : bus.addr0;
                        wdata_l <= winner ? bus.wdata1 : bus.wdata0;
                        gnt0_q  <= ~winner;
                        gnt1_q  <= winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_owner <= winner;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    state       <= ACCESS;
                    mem_addr_q  <= addr_l;
                    mem_wdata_q <= wdata_l;
                    mem_rd_q    <= ~we_l;
                    mem_wr_q    <= we_l;
                end
                ACCESS: begin
                    state   <= RESP;
                    done0_q <= ~owner;
                    done1_q <= owner;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.busy      = busy_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = (state == RESP && !we_l) ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences and a
// randomized phase checked against a transaction-level model of arbitration and memory.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.AW(5), .DW(8)) bus ();

    mem_port_arbiter #(.AW(5), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with a registered read: data appears the cycle after mem_rd.
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        bit         port;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive_port(input bit p, input bit req, input bit we, input logic [4:0] addr, input logic [7:0] wdata);
        if (p) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete transfer from an idle arbiter, checked cycle by cycle.
    task automatic apply_stimulus(input bit p, input bit we, input logic [4:0] addr,
                                  input logic [7:0] wdata, input logic [7:0] exp_rdata, input string tag);
        int waited;
        bit got;
        @(negedge clk);
        drive_port(p, 1'b1, we, addr, wdata);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            got = p ? bus.gnt1 : bus.gnt0;
        end
        check_output({tag, "_gnt_seen"}, 32'(got), 32'd1);
        check_output({tag, "_gnt_latency"}, 32'(waited), 32'd1);
        check_output({tag, "_busy_grant"}, 32'(bus.busy), 32'd1);
        drive_port(p, 1'b0, we, addr, wdata);
        @(negedge clk);
        check_output({tag, "_strobe"}, 32'({bus.mem_rd, bus.mem_wr}), 32'({~we, we}));
        check_output({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(addr));
        if (we) check_output({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(wdata));
        @(negedge clk);
        check_output({tag, "_done"}, 32'({bus.done1, bus.done0}), p ? 32'd2 : 32'd1);
        check_output({tag, "_busy_resp"}, 32'(bus.busy), 32'd1);
        if (!we) check_output({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rdata));
        else ref_mem[addr] = wdata;
        @(negedge clk);
        check_output({tag, "_idle"}, 32'({bus.busy, bus.done1, bus.done0}), 32'd0);
        if (!we) check_output({tag, "_rdata_hold"}, 32'(bus.rdata), 32'(exp_rdata));
    endtask

    // Random transfers, single or simultaneous, checked against arbitration rules and ref_mem.
    task automatic run_random(input int n);
        bit         model_last;
        bit         t_we    [2];
        logic [4:0] t_addr  [2];
        logic [7:0] t_wdata [2];
        bit         exp_order [$];
        bit         srv;
        bit         dual;
        bit         p;
        bit         first;
        bit         finished;
        int         gidx;
        int         ndone;
        model_last = 1'b1;
        for (int it = 0; it < n; it++) begin
            dual = ($urandom_range(0, 2) == 0);
            p    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++) begin
                t_we[k]    = 1'($urandom_range(0, 1));
                t_addr[k]  = 5'($urandom_range(0, 31));
                t_wdata[k] = 8'($urandom_range(0, 255));
            end
            exp_order.delete();
            if (dual) begin
                first = FIXED_PRIO ? 1'b1 : ~model_last;
                exp_order.push_back(first);
                exp_order.push_back(~first);
            end else begin
                exp_order.push_back(p);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (dual || p == k[0]) drive_port(k[0], 1'b1, t_we[k], t_addr[k], t_wdata[k]);
            gidx = 0;
            ndone = 0;
            srv = exp_order[0];
            finished = 1'b0;
            for (int cyc = 0; cyc < 30 && !finished; cyc++) begin
                @(negedge clk);
                if (bus.gnt0 || bus.gnt1) begin
                    check_output("rand_gnt_onehot", 32'({bus.gnt1, bus.gnt0}), bus.gnt1 ? 32'd2 : 32'd1);
                    if (gidx < exp_order.size()) begin
                        check_output("rand_gnt_port", 32'(bus.gnt1), 32'(exp_order[gidx]));
                        srv = exp_order[gidx];
                        model_last = srv;
                        drive_port(srv, 1'b0, t_we[srv], t_addr[srv], t_wdata[srv]);
                    end else begin
                        check_output("rand_extra_gnt", 32'd1, 32'd0);
                    end
                    gidx++;
                end
                if (bus.mem_rd || bus.mem_wr) begin
                    check_output("rand_strobe", 32'({bus.mem_rd, bus.mem_wr}), 32'({~t_we[srv], t_we[srv]}));
                    check_output("rand_mem_addr", 32'(bus.mem_addr), 32'(t_addr[srv]));
                    if (t_we[srv]) check_output("rand_mem_wdata", 32'(bus.mem_wdata), 32'(t_wdata[srv]));
                end
                if (bus.done0 || bus.done1) begin
                    check_output("rand_done_port", 32'({bus.done1, bus.done0}), srv ? 32'd2 : 32'd1);
                    if (t_we[srv]) ref_mem[t_addr[srv]] = t_wdata[srv];
                    else check_output("rand_rdata", 32'(bus.rdata), 32'(ref_mem[t_addr[srv]]));
                    ndone++;
                end
                if (ndone == exp_order.size() && !bus.busy) finished = 1'b1;
            end
            check_output("rand_complete", 32'(finished), 32'd1);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         exp_p;
        int         k;
        int         ph;
        logic [1:0] exp_pulse;
        bit         gnt0_seen;
        bit         done1_seen;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 8'(i * 3);
            ref_mem[i] = 8'(i * 3);
        end
        mem[5'h0A]     = 8'h3C;
        ref_mem[5'h0A] = 8'h3C;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_rdata = '0;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 5'h0A, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 5'h1F, wdata: 8'hA5, exp_rdata: 8'h00};
        vecs[2] = '{port: 1'b0, we: 1'b0, addr: 5'h1F, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[3] = '{port: 1'b1, we: 1'b1, addr: 5'h05, wdata: 8'h5A, exp_rdata: 8'h00};
        vecs[4] = '{port: 1'b1, we: 1'b0, addr: 5'h05, wdata: 8'h00, exp_rdata: 8'h5A};
        vecs[5] = '{port: 1'b0, we: 1'b1, addr: 5'h00, wdata: 8'hFF, exp_rdata: 8'h00};
        vecs[6] = '{port: 1'b1, we: 1'b0, addr: 5'h00, wdata: 8'h00, exp_rdata: 8'hFF};

        rst = 1'b1;
        #12;
        check_output("reset_pulses", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), 32'd0);
        check_output("reset_strobes", 32'({bus.mem_rd, bus.mem_wr, bus.busy}), 32'd0);
        check_output("reset_rdata", 32'(bus.rdata), 32'd0);
        check_output("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_output("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 7; i++)
            apply_stimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                           vecs[i].exp_rdata, $sformatf("vec%0d", i));

        $display("[TB] both ports held continuously");
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'h0A;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'h1F;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            k  = (c - 1) / 3;
            ph = (c - 1) % 3;
            exp_p     = FIXED_PRIO ? 1'b1 : 1'(k % 2);
            exp_pulse = exp_p ? 2'b10 : 2'b01;
            check_output($sformatf("hold_gnt_c%0d", c), 32'({bus.gnt1, bus.gnt0}), (ph == 0) ? 32'(exp_pulse) : 32'd0);
            check_output($sformatf("hold_done_c%0d", c), 32'({bus.done1, bus.done0}), (ph == 2) ? 32'(exp_pulse) : 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check_output("hold_back_to_idle", 32'(bus.busy), 32'd0);

        $display("[TB] reset during a read access");
        do_reset();
        drive_port(1'b0, 1'b1, 1'b0, 5'h0A, 8'h00);
        @(negedge clk);
        check_output("abort_gnt0", 32'(bus.gnt0), 32'd1);
        drive_port(1'b0, 1'b0, 1'b0, 5'h0A, 8'h00);
        @(negedge clk);
        check_output("abort_mem_rd_before", 32'(bus.mem_rd), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_output("abort_mem_rd_async", 32'(bus.mem_rd), 32'd0);
        check_output("abort_busy_async", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_output("abort_no_done", 32'({bus.done1, bus.done0}), 32'd0);
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 5'h0A, 8'h00, 8'h3C, "abort_recover");

        $display("[TB] short req0 pulse during port 1 access");
        @(negedge clk);
        drive_port(1'b1, 1'b1, 1'b1, 5'h07, 8'h77);
        @(negedge clk);
        check_output("pulse_gnt1", 32'(bus.gnt1), 32'd1);
        drive_port(1'b1, 1'b0, 1'b1, 5'h07, 8'h77);
        @(negedge clk);
        check_output("pulse_mem_wr", 32'(bus.mem_wr), 32'd1);
        drive_port(1'b0, 1'b1, 1'b0, 5'h07, 8'h00);
        gnt0_seen  = 1'b0;
        done1_seen = 1'b0;
        @(negedge clk);
        drive_port(1'b0, 1'b0, 1'b0, 5'h07, 8'h00);
        done1_seen = bus.done1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.gnt0) gnt0_seen = 1'b1;
        end
        ref_mem[5'h07] = 8'h77;
        check_output("pulse_done1", 32'(done1_seen), 32'd1);
        check_output("pulse_no_gnt0", 32'(gnt0_seen), 32'd0);
        check_output("pulse_idle", 32'(bus.busy), 32'd0);

        $display("[TB] back-to-back writes from port 0");
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 5'h02, 8'h11);
        @(negedge clk);
        check_output("b2b_gnt_a", 32'(bus.gnt0), 32'd1);
        drive_port(1'b0, 1'b1, 1'b1, 5'h03, 8'h22);
        @(negedge clk);
        check_output("b2b_wr_a", 32'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 5'h02, 8'h11}));
        @(negedge clk);
        check_output("b2b_done_a", 32'(bus.done0), 32'd1);
        @(negedge clk);
        check_output("b2b_gnt_b", 32'({bus.busy, bus.gnt0}), 32'd3);
        drive_port(1'b0, 1'b0, 1'b1, 5'h03, 8'h22);
        @(negedge clk);
        check_output("b2b_wr_b", 32'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 5'h03, 8'h22}));
        @(negedge clk);
        check_output("b2b_done_b", 32'(bus.done0), 32'd1);
        ref_mem[5'h02] = 8'h11;
        ref_mem[5'h03] = 8'h22;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 5'h02, 8'h00, 8'h11, "b2b_read_a");
        apply_stimulus(1'b1, 1'b0, 5'h03, 8'h00, 8'h22, "b2b_read_b");

        $display("[TB] randomized transfers");
        do_reset();
        run_random(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
